// File: rtl/sar_ctrl_nonbinary_param_if.sv
// Result handshake bundle between the SAR controller and the readout logic.
// The controller drives the result side (master); the consumer returns result_ready.
interface sar_ctrl_nonbinary_param_if #(
  parameter int MATRIX_BITS = 12
) ();
  logic [MATRIX_BITS-1:0] result;
  logic                   result_valid;
  logic                   result_ready;
  logic                   overrun;

  modport master (output result, output result_valid, output overrun, input result_ready);
  modport slave  (input result, input result_valid, input overrun, output result_ready);
endinterface

// File: rtl/sar_ctrl_nonbinary_param.sv
// Non-binary SAR controller: sample phase, redundant successive-approximation search, result handshake.
// Optional macro SAR_LSB_AVERAGING_EN adds majority-vote averaging over the last LSB_STEPS decisions.
module sar_ctrl_nonbinary_param #(
  parameter int MATRIX_BITS = 12,
  parameter int NB_STEPS = 15,
  parameter logic [NB_STEPS*MATRIX_BITS-1:0] WEIGHTS = {
    12'd2048, 12'd806, 12'd486, 12'd295, 12'd180, 12'd110, 12'd67, 12'd41,
    12'd25, 12'd15, 12'd9, 12'd6, 12'd4, 12'd2, 12'd1},
  parameter int LSB_STEPS = 4,
  parameter int SAMPLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start,
  input  logic                   cont,
  input  logic                   comparator_in,
  input  logic [2:0]             avg_control,
  output logic                   sample,
  output logic                   nsample,
  output logic                   enable,
  output logic [MATRIX_BITS-1:0] n_switch,
  output logic [MATRIX_BITS-1:0] p_switch,
  sar_ctrl_nonbinary_param_if.master res_if
);

  localparam int STEP_W  = $clog2(NB_STEPS + 1);
  localparam int CNT_MAX = (SAMPLE_CYCLES > 32) ? SAMPLE_CYCLES : 32;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(NB_STEPS - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);

  function automatic longint unsigned weight_sum();
    longint unsigned s = 0;
    for (int i = 0; i < NB_STEPS; i++) s += 64'(WEIGHTS[i*MATRIX_BITS +: MATRIX_BITS]);
    return s;
  endfunction

  localparam longint unsigned WEIGHT_SUM = weight_sum();

  if (WEIGHT_SUM > ((64'd1 << MATRIX_BITS) - 64'd1)) begin : g_bad_weights
    $error("sar_ctrl_nonbinary_param: sum of WEIGHTS exceeds 2^MATRIX_BITS-1");
  end
  if (LSB_STEPS > NB_STEPS) begin : g_bad_lsb_steps
    $error("sar_ctrl_nonbinary_param: LSB_STEPS must not exceed NB_STEPS");
  end
  if (SAMPLE_CYCLES < 1) begin : g_bad_sample_cycles
    $error("sar_ctrl_nonbinary_param: SAMPLE_CYCLES must be at least 1");
  end

  // Step 0 lives in the most significant slice of WEIGHTS.
  function automatic logic [MATRIX_BITS-1:0] weight_at(input logic [STEP_W-1:0] k);
    return WEIGHTS[(NB_STEPS - 1 - int'(k))*MATRIX_BITS +: MATRIX_BITS];
  endfunction

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV} state_t;

  state_t                 state, state_nxt;
  logic [MATRIX_BITS-1:0] data, trial, data_nxt;
  logic [STEP_W-1:0]      step;
  logic [CNT_W-1:0]       cnt;
  logic                   step_done, keep, last_step, go, finish;

  assign trial     = data + weight_at(step);
  assign last_step = (step == LAST_STEP);
  assign data_nxt  = keep ? trial : data;

`ifdef SAR_LSB_AVERAGING_EN
  localparam logic [STEP_W-1:0] FIRST_LSB = STEP_W'(NB_STEPS - LSB_STEPS);

  function automatic logic [4:0] avg_len_m1(input logic [2:0] sel);
    case (sel)
      3'b001:  return 5'd2;
      3'b010:  return 5'd6;
      3'b011:  return 5'd14;
      3'b100:  return 5'd30;
      default: return 5'd0;
    endcase
  endfunction

  // Strict majority of N = len_m1+1 votes: sum >= (N+1)/2.
  function automatic logic majority(input logic [5:0] sum, input logic [4:0] len_m1);
    return sum >= ((6'(len_m1) + 6'd2) >> 1);
  endfunction

  logic       in_lsb;
  logic [5:0] acc, acc_sum;
  logic [4:0] n_m1;

  assign in_lsb    = (step >= FIRST_LSB);
  assign acc_sum   = acc + 6'(comparator_in);
  assign step_done = !in_lsb || (cnt == CNT_W'(n_m1));
  assign keep      = in_lsb ? majority(acc_sum, n_m1) : comparator_in;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc  <= '0;
      n_m1 <= '0;
    end else begin
      if (go) n_m1 <= avg_len_m1(avg_control);
      if (state != CONV || step_done) acc <= '0;
      else                            acc <= acc_sum;
    end
  end
`else
  logic unused_avg;

  assign unused_avg = ^avg_control;
  assign step_done  = 1'b1;
  assign keep       = comparator_in;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sample    = 1'b1;
    nsample   = 1'b0;
    enable    = 1'b0;
    n_switch  = '0;
    go        = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start || cont) begin
          state_nxt = SAMPLE;
          go        = 1'b1;
        end
      end
      SAMPLE: begin
        if (cnt == SAMPLE_LAST) state_nxt = CONV;
      end
      CONV: begin
        sample   = 1'b0;
        nsample  = 1'b1;
        enable   = 1'b1;
        n_switch = trial;
        if (step_done && last_step) begin
          finish = 1'b1;
          if (cont) begin
            state_nxt = SAMPLE;
            go        = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign p_switch = ~n_switch;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data                <= '0;
      step                <= '0;
      cnt                 <= '0;
      res_if.result       <= '0;
      res_if.result_valid <= 1'b0;
      res_if.overrun      <= 1'b0;
    end else begin
      res_if.overrun <= 1'b0;
      if (go) begin
        data <= '0;
        step <= '0;
        cnt  <= '0;
      end else if (state == SAMPLE) begin
        cnt <= (cnt == SAMPLE_LAST) ? '0 : cnt + 1'b1;
      end else if (state == CONV) begin
        if (step_done) begin
          data <= data_nxt;
          step <= step + 1'b1;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      // A completing conversion wins over a same-edge ready.
      if (finish) begin
        res_if.result       <= data_nxt;
        res_if.result_valid <= 1'b1;
        res_if.overrun      <= res_if.result_valid && !res_if.result_ready;
      end else if (res_if.result_ready) begin
        res_if.result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sar_ctrl_nonbinary_param.md
# sar_ctrl_nonbinary_param

Parametrised successor controller for the SKY130 non-binary SAR ADC. It sequences sampling and a redundant (non-binary-weighted) successive-approximation search over the capacitor matrix. Decisions in the LSB steps can be majority-averaged. The block adds single-shot/continuous modes, a configurable sample phase and a valid/ready result handshake with overrun reporting. It sits between the comparator/capacitor-matrix switches and the digital readout logic.

## Interface
- MATRIX_BITS, 12, capacitor-matrix and result width.
- NB_STEPS, 15, number of decision steps per conversion.
- WEIGHTS, packed {2048,806,486,295,180,110,67,41,25,15,9,6,4,2,1}, NB_STEPS×MATRIX_BITS; step 0 (MSB) in the most significant slice.
- LSB_STEPS, 4, number of final steps eligible for averaging; must be ≤ NB_STEPS.
- SAMPLE_CYCLES, 1, length of the sample phase in clocks; must be ≥ 1.
- clk  in  1  clock; all state changes on the rising edge.
- nrst  in  1  reset; asynchronous, active-low.
- start  in  1  single-shot request; honoured only in IDLE.
- cont  in  1  continuous mode: back-to-back conversions while high.
- comparator_in  in  1  1 = keep current trial weight.
- avg_control  in  3  averaging select: 001→3, 010→7, 011→15, 100→31 samples; any other value→1.
- sample / nsample  out  1  sampling switch and its complement.
- enable  out  1  comparator enable; high during CONV only.
- n_switch  out  MATRIX_BITS  trial code during CONV, 0 otherwise.
- p_switch  out  MATRIX_BITS  bitwise complement of n_switch.
- result  out  MATRIX_BITS  last completed conversion.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- overrun  out  1  one-cycle pulse when an unread result is overwritten.

## Operation
- States are IDLE, SAMPLE and CONV. Reset enters IDLE with data=0, result=0, result_valid=0, overrun=0.
- Output levels by state:
  - IDLE and SAMPLE: sample=1, nsample=0, enable=0, n_switch=0, p_switch=all ones.
  - CONV: sample=0, nsample=1, enable=1.
- IDLE→SAMPLE on an edge where start=1 or cont=1. avg_control is latched on that edge and held for the whole conversion.
- SAMPLE lasts SAMPLE_CYCLES cycles. On entry, data is cleared to 0 and the step index to 0.
- CONV, step k:
  - Drive trial = data + WEIGHTS[k] onto n_switch.
  - Steps k < NB_STEPS−LSB_STEPS take one cycle. comparator_in is sampled at the step's closing edge; if 1, data ← trial.
  - LSB steps with average count N hold the trial for N cycles and sum comparator_in into a 6-bit accumulator.
  - An LSB-step decision is 1 iff sum ≥ (N+1)/2, i.e. a strict majority.
  - The accumulator resets at each new step.
- After the last step's closing edge:
  - result ← final data, result_valid ← 1.
  - The state goes to SAMPLE if cont=1 at that edge, otherwise to IDLE.
- Handshake:
  - result_valid clears on an edge where result_ready=1, unless a new result completes on the same edge; then valid stays 1 with the new value and overrun stays 0.
  - If a result completes while result_valid=1 and result_ready=0, result is overwritten and overrun pulses for one cycle.
- Arithmetic and parameter rules:
  - Trial additions are MATRIX_BITS wide and wrap modulo 2^MATRIX_BITS.
  - The sum of WEIGHTS must be ≤ 2^MATRIX_BITS−1. This is checked by an elaboration-time assertion, so no wrap occurs in legal configurations.
- Boundary cases:
  - start is ignored outside IDLE.
  - cont falling mid-conversion lets the current conversion finish, then the block returns to IDLE.
  - nrst asserted mid-conversion aborts immediately to the reset state; a partial result is never published.

## Timing
- Start latency: start sampled at edge E0 → sample phase covers cycles E0..E0+SAMPLE_CYCLES−1 → first trial drives in the cycle after E0+SAMPLE_CYCLES−1.
- Conversion latency: result_valid rises at edge E0 + SAMPLE_CYCLES + NB_STEPS + LSB_STEPS·(N−1).
- Defaults with N=1: 16 cycles from start to result_valid.
- n_switch, p_switch and enable are registered-state decodes with no comparator-to-switch combinational path inside one step.
- Continuous-mode throughput: one result every SAMPLE_CYCLES + NB_STEPS + LSB_STEPS·(N−1) cycles.

## Configuration
- SAR_LSB_AVERAGING_EN defined: the averaging datapath is present; avg_control is latched and honoured as above.
- SAR_LSB_AVERAGING_EN undefined:
  - The averaging logic is removed and avg_control is ignored.
  - Every step takes one cycle with N=1.
  - Latency is fixed at SAMPLE_CYCLES + NB_STEPS.

## Test plan
- Defaults, start pulse, comparator_in held 1 → result=4095, result_valid rises 16 cycles after the start edge.
- Defaults, comparator_in held 0 → result=0; n_switch sequence 2048, 806, 486, … 1 observed across the 15 CONV cycles.
- Comparator model comparator_in=(trial ≤ 1000) → result=1000; accepted weights 806, 180, 9, 4, 1.
- avg_control=010, model as above but forcing 4/7 ones in step 12 and 3/7 ones in step 13:
  - latency = 1+15+4·6 = 40 cycles;
  - step 12 kept, step 13 rejected.
- cont=1, result_ready=0 for two conversions → overrun pulses once, result holds the second value. Then result_ready=1 coincident with a completing conversion → valid stays 1, overrun stays 0.
- nrst pulsed low at CONV step 5 → all outputs return to reset values, result_valid stays 0. A following start yields a full, correct conversion.
